// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit controller.
//   - lsu_state_e : controller state encoding (SPLIT only exists when the
//                   LSU_MISALIGN_SPLIT_EN macro is defined)
//   - LB..SW      : RISC-V load/store funct3 encodings
//   - access_size : bytes touched by an access of a given funct3
//   - funct3_legal, misaligned, out_of_range : request classification helpers
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
package lsu_pkg;

    localparam logic [31:0] DMEM_RANGE_DEFAULT = 32'h07ff_ffff;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
`ifdef LSU_MISALIGN_SPLIT_EN
        ST_SPLIT  = 2'd2,
`endif
        ST_RESP   = 2'd3
    } lsu_state_e;

    // Width is carried in funct3[1:0]; bit 2 only selects zero-extension.
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        else
            return (f3 == LB) || (f3 == LH) || (f3 == LW) ||
                   (f3 == LBU) || (f3 == LHU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Last byte computed in 33 bits so an access wrapping past 2^32 is caught.
    function automatic logic out_of_range(input logic [31:0] addr,
                                          input logic [2:0]  f3,
                                          input logic [31:0] range);
        logic [32:0] last_byte;
        last_byte = {1'b0, addr} + {30'b0, access_size(f3)} - 33'd1;
        return last_byte > {1'b0, range};
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response handshake between the execute stage and the
// load/store unit.
//   master : execute stage (drives req_*, resp_ready)
//   slave  : lsu_ctrl      (drives req_ready, resp_*)
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_extend.sv
// lsu_extend: combinational load-data formatting.
//   raw_word   : LSB-aligned raw load data
//   ext_funct3 : load funct3 selecting sign/zero extension
//   ext_word   : extended load result
// With LSU_MISALIGN_SPLIT_EN defined it also assembles split byte loads:
//   byte_in/byte_idx : byte just read and its lane (little-endian)
//   asm_word         : raw_word with that lane replaced
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [2:0]  ext_funct3,
    output logic [31:0] ext_word
`ifdef LSU_MISALIGN_SPLIT_EN
    ,
    input  logic [7:0]  byte_in,
    input  logic [1:0]  byte_idx,
    output logic [31:0] asm_word
`endif
);

    always_comb begin
        ext_word = raw_word;
        case (ext_funct3)
            LB:      ext_word = {{24{raw_word[7]}}, raw_word[7:0]};
            LH:      ext_word = {{16{raw_word[15]}}, raw_word[15:0]};
            LBU:     ext_word = {24'b0, raw_word[7:0]};
            LHU:     ext_word = {16'b0, raw_word[15:0]};
            default: ext_word = raw_word;
        endcase
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign asm_word[8*gi +: 8] = (byte_idx == 2'(gi)) ? byte_in
                                                          : raw_word[8*gi +: 8];
    end
`endif

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between the execute stage and a
// combinational-read, falling-edge-write data memory.
//   clk, rst  : clock, asynchronous active-high reset
//   lsu       : lsu_ctrl_if.slave request/response handshake
//   Address, WriteData, MemRW (1=read, 0=write), funct3 : dmem controls
//   ReadData  : dmem combinational read data
// Parameter DMEM_RANGE: highest valid dmem byte address.
// Optional feature macro LSU_MISALIGN_SPLIT_EN: misaligned legal requests
// are executed as ascending single-byte accesses instead of being rejected.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_RANGE = DMEM_RANGE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    lsu_ctrl_if.slave       lsu,
    output logic [31:0]     Address,
    output logic [31:0]     WriteData,
    output logic            MemRW,
    output logic [2:0]      funct3,
    input  logic [31:0]     ReadData
);

    lsu_state_e  state_q, state_d;
    logic        we_q,    we_d;
    logic [2:0]  f3_q,    f3_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q,  data_d;
    logic        err_q,   err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]  idx_q,   idx_d;
    logic [1:0]  split_last;
    logic [2:0]  split_size;
    logic [31:0] asm_word;
`endif

    logic        accept;
    logic        req_bad;
    logic        req_misal;
    logic [31:0] ext_word;

    // req_ready is masked by rst so nothing is offered while reset is held.
    assign lsu.req_ready = (state_q == ST_IDLE) && !rst;
    assign accept        = lsu.req_valid && lsu.req_ready;
    assign req_misal     = misaligned(lsu.req_funct3, lsu.req_addr[1:0]);

`ifdef LSU_MISALIGN_SPLIT_EN
    assign req_bad = !funct3_legal(lsu.req_we, lsu.req_funct3) ||
                     out_of_range(lsu.req_addr, lsu.req_funct3, DMEM_RANGE);
    assign split_size = access_size(f3_q);
    // Size 4 wraps 3'd4[1:0]=0 to 3 after the decrement, which is intended.
    assign split_last = split_size[1:0] - 2'd1;
`else
    assign req_bad = !funct3_legal(lsu.req_we, lsu.req_funct3) ||
                     out_of_range(lsu.req_addr, lsu.req_funct3, DMEM_RANGE) ||
                     req_misal;
`endif

    lsu_extend u_extend (
        .raw_word   (data_q),
        .ext_funct3 (f3_q),
        .ext_word   (ext_word)
`ifdef LSU_MISALIGN_SPLIT_EN
        ,
        .byte_in    (ReadData[7:0]),
        .byte_idx   (idx_q),
        .asm_word   (asm_word)
`endif
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        idx_d   = idx_q;
`endif
        // Idle dmem drive: read of a byte at address 0 can never write.
        Address        = 32'b0;
        WriteData      = 32'b0;
        MemRW          = 1'b1;
        funct3         = LBU;
        lsu.resp_valid = 1'b0;
        lsu.resp_err   = 1'b0;
        lsu.resp_rdata = 32'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = lsu.req_we;
                    f3_d    = lsu.req_funct3;
                    addr_d  = lsu.req_addr;
                    wdata_d = lsu.req_wdata;
                    data_d  = 32'b0;
                    err_d   = req_bad;
`ifdef LSU_MISALIGN_SPLIT_EN
                    idx_d   = 2'd0;
`endif
                    if (req_bad)
                        state_d = ST_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
                    else if (req_misal)
                        state_d = ST_SPLIT;
`endif
                    else
                        state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                Address   = addr_q;
                WriteData = wdata_q;
                MemRW     = ~we_q;
                funct3    = f3_q;
                data_d    = ReadData;
                state_d   = ST_RESP;
            end

`ifdef LSU_MISALIGN_SPLIT_EN
            ST_SPLIT: begin
                Address   = addr_q + {30'b0, idx_q};
                WriteData = {24'b0, wdata_q[{idx_q, 3'b000} +: 8]};
                MemRW     = ~we_q;
                funct3    = we_q ? SB : LBU;
                data_d    = asm_word;
                if (idx_q == split_last)
                    state_d = ST_RESP;
                else
                    idx_d = idx_q + 2'd1;
            end
`endif

            ST_RESP: begin
                lsu.resp_valid = 1'b1;
                lsu.resp_err   = err_q;
                lsu.resp_rdata = (!err_q && !we_q) ? ext_word : 32'b0;
                if (lsu.resp_ready)
                    state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            data_q  <= 32'b0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            idx_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            idx_q   <= idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl with a byte-array dmem model.
// Expected responses (err, rdata, latency) are queued when a request is
// accepted and compared when the response appears.
module tb_lsu_ctrl;
    import lsu_pkg::*;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Address, WriteData, ReadData;
    logic        MemRW;
    logic [2:0]  funct3;

    lsu_ctrl_if bus();

    lsu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .lsu       (bus),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRW     (MemRW),
        .funct3    (funct3),
        .ReadData  (ReadData)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dmem model: 4 KiB window (address bits [11:0]), falling-edge writes.
    logic [7:0]  mem [0:4095];
    logic [11:0] rd_a;
    int          wr_cnt = 0;
    initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    function automatic int wr_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    assign rd_a     = Address[11:0];
    assign ReadData = {mem[rd_a + 12'd3], mem[rd_a + 12'd2], mem[rd_a + 12'd1], mem[rd_a]};

    always @(negedge clk) begin
        if (!MemRW) begin
            wr_cnt <= wr_cnt + 1;
            for (int i = 0; i < 4; i++)
                if (i < wr_size(funct3))
                    mem[Address[11:0] + 12'(i)] <= WriteData[8*i +: 8];
        end
    end

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   resp_hold = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on each new response and, when a
    // hold is requested, keeps resp_ready low and checks the response is stable.
    initial begin
        bit   active;
        int   remaining;
        exp_t cur;
        active    = 0;
        remaining = 0;
        bus.resp_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
                remaining = 0;
                bus.resp_ready = 1'b1;
            end else if (active && remaining > 0) begin
                chk("hold_valid", 32'(bus.resp_valid), 1);
                chk("hold_rdata", bus.resp_rdata, cur.rdata);
                chk("hold_err", 32'(bus.resp_err), 32'(cur.err));
                chk("hold_req_ready", 32'(bus.req_ready), 0);
                remaining--;
                if (remaining == 0) bus.resp_ready = 1'b1;
            end else if (bus.resp_valid && !active) begin
                active = 1;
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(sb.size()), 1);
                end else begin
                    cur = sb.pop_front();
                    chk("resp_err", 32'(bus.resp_err), 32'(cur.err));
                    chk("resp_rdata", bus.resp_rdata, cur.rdata);
                    chk("resp_latency", 32'(cyc + 1 - cur.acc), 32'(cur.lat));
                    chk("resp_memrw", 32'(MemRW), 1);
                    $display("resp @%0d err=%0d rdata=%h lat=%0d", cyc,
                             bus.resp_err, bus.resp_rdata, cyc + 1 - cur.acc);
                    if (resp_hold > 0) begin
                        bus.resp_ready = 1'b0;
                        remaining = resp_hold;
                    end
                end
            end else if (!bus.resp_valid) begin
                active = 0;
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.resp_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || bus.resp_valid)
            chk("drain_timeout", 32'(sb.size()), 0);
        @(negedge clk);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic exp_err,
                          input logic [31:0] exp_rd, input int exp_lat, input int hold);
        exp_t e;
        int   waited;
        int   wr_before;
        resp_hold = hold;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        #1;
        waited = 0;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.req_ready) begin
            chk("req_ready_timeout", 32'(bus.req_ready), 1);
            bus.req_valid = 1'b0;
            return;
        end
        wr_before = wr_cnt;
        e.err   = exp_err;
        e.rdata = exp_rd;
        e.lat   = exp_lat;
        e.acc   = cyc + 1;
        sb.push_back(e);
        $display("req  @%0d we=%0d f3=%b addr=%h wdata=%h", cyc + 1, we, f3, addr, wd);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_done();
        resp_hold = 0;
        if (exp_err) chk("err_no_write", 32'(wr_cnt), 32'(wr_before));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b0;
        bus.req_addr   = 32'b0;
        bus.req_wdata  = 32'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_err", 32'(bus.resp_err), 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_memrw", 32'(MemRW), 1);
        chk("rst_address", Address, 0);
        chk("rst_wdata", WriteData, 0);
        chk("rst_funct3", 32'(funct3), 32'(3'b100));
        rst = 1'b0;

        // Word store/load round trip.
        do_req(1, SW, 32'h100, 32'h1122_3344, 0, 32'h0, 2, 0);
        do_req(0, LW, 32'h100, 32'h0, 0, 32'h1122_3344, 2, 0);
        // Byte store (only lane 0 written) and sign/zero-extended reads.
        do_req(1, SB, 32'h200, 32'hDEAD_BE80, 0, 32'h0, 2, 0);
        do_req(0, LB, 32'h200, 32'h0, 0, 32'hFFFF_FF80, 2, 0);
        do_req(0, LBU, 32'h200, 32'h0, 0, 32'h0000_0080, 2, 0);
        // Misaligned halfword store/load: split or rejected.
        do_req(1, SH, 32'h201, 32'h0000_8001, !SPLIT, 32'h0, SPLIT ? 3 : 1, 0);
        do_req(0, LH, 32'h201, 32'h0, !SPLIT, SPLIT ? 32'hFFFF_8001 : 32'h0, SPLIT ? 3 : 1, 0);
        do_req(0, LH, 32'h200, 32'h0, 0, SPLIT ? 32'h0000_0180 : 32'h0000_0080, 2, 0);
        do_req(0, LW, 32'h200, 32'h0, 0, SPLIT ? 32'h0080_0180 : 32'h0000_0080, 2, 0);
        do_req(0, LHU, 32'h201, 32'h0, !SPLIT, SPLIT ? 32'h0000_8001 : 32'h0, SPLIT ? 3 : 1, 0);
        do_req(0, LW, 32'h201, 32'h0, !SPLIT, SPLIT ? 32'h0000_8001 : 32'h0, SPLIT ? 5 : 1, 0);
        // Illegal funct3 for loads and stores.
        do_req(0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 1, 0);
        do_req(1, 3'b011, 32'h100, 32'hFFFF_FFFF, 1, 32'h0, 1, 0);
        do_req(1, 3'b100, 32'h100, 32'hFFFF_FFFF, 1, 32'h0, 1, 0);
        chk("mem_after_illegal", 32'(mem[12'h100]), 32'h44);
        // Range boundary, including last-byte and 32-bit wrap cases.
        do_req(0, LW, 32'h07FF_FFFE, 32'h0, 1, 32'h0, 1, 0);
        do_req(0, LW, 32'h07FF_FFFD, 32'h0, 1, 32'h0, 1, 0);
        do_req(0, LH, 32'h07FF_FFFF, 32'h0, 1, 32'h0, 1, 0);
        do_req(1, SW, 32'hFFFF_FFFC, 32'h1234_5678, 1, 32'h0, 1, 0);
        do_req(0, LW, 32'h07FF_FFFC, 32'h0, 0, 32'h0, 2, 0);
        do_req(1, SB, 32'h07FF_FFFF, 32'h0000_005A, 0, 32'h0, 2, 0);
        do_req(0, LBU, 32'h07FF_FFFF, 32'h0, 0, 32'h0000_005A, 2, 0);
        // Response back-pressure for 5 cycles.
        do_req(0, LW, 32'h100, 32'h0, 0, 32'h1122_3344, 2, 5);

`ifdef LSU_MISALIGN_SPLIT_EN
        // Reset during a split word store after two bytes have been written.
        wr_before = wr_cnt;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = SW;
        bus.req_addr   = 32'h301;
        bus.req_wdata  = 32'hAABB_CCDD;
        #1;
        chk("split_rst_ready", 32'(bus.req_ready), 1);
        $display("req  @%0d we=1 f3=010 addr=00000301 wdata=aabbccdd (reset mid-split)", cyc + 1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("split_rst_memrw", 32'(MemRW), 1);
        chk("split_rst_req_ready", 32'(bus.req_ready), 0);
        chk("split_rst_resp_valid", 32'(bus.resp_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("split_rst_byte0", 32'(mem[12'h301]), 32'hDD);
        chk("split_rst_byte1", 32'(mem[12'h302]), 32'hCC);
        chk("split_rst_byte2", 32'(mem[12'h303]), 32'h00);
        chk("split_rst_writes", 32'(wr_cnt - wr_before), 2);
`else
        do_req(1, SW, 32'h301, 32'hAABB_CCDD, 1, 32'h0, 1, 0);
        chk("nosplit_byte0", 32'(mem[12'h301]), 32'h00);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_pulse_req_ready", 32'(bus.req_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
`endif
        #1;
        chk("ready_after_rst", 32'(bus.req_ready), 1);
        chk("no_resp_after_rst", 32'(bus.resp_valid), 0);
        do_req(0, LW, 32'h100, 32'h0, 0, 32'h1122_3344, 2, 0);

        chk("sb_empty_end", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
